// File: rtl/dram_transfer_engine_pkg.sv
// Shared types for the link-side DRAM transfer engine.
package dram_transfer_engine_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StBwd,
    StDone
  } xfer_state_t;

endpackage

// File: rtl/sync_fwft_fifo.sv
// First-word-fall-through FIFO with occupancy count; rst_ni is synchronous.
module sync_fwft_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned AW = $clog2(FIFO_DEPTH),
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  empty_o,
  output logic [CW-1:0]         count_o
);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop_i && (count_q != '0);
    // A push into a full FIFO is fine when a pop frees a slot in the same cycle.
    push_ok  = push_i && ((count_q != CW'(FIFO_DEPTH)) || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/dram_transfer_engine.sv
// Link-side DRAM transfer engine: credit-limited forward reads into a FIFO,
// single-register backward writes, per-type persistent address pointers.
module dram_transfer_engine
  import dram_transfer_engine_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned WORDS_WIDTH = 16,
  parameter int unsigned NUM_TYPES   = 4,
  parameter int unsigned TYPE_WIDTH  = $clog2(NUM_TYPES),
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                            link_clk,
  input  logic                            reset,
  input  logic                            start_forward,
  input  logic                            start_backward,
  input  logic [TYPE_WIDTH-1:0]           transfer_type,
  input  logic                            transfer_continue,
  input  logic [WORDS_WIDTH-1:0]          words_num,
  input  logic [NUM_TYPES*ADDR_WIDTH-1:0] base_addr,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_WIDTH-1:0]           mem_wdata,
  input  logic                            mem_gnt,
  input  logic                            mem_rvalid,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic [DATA_WIDTH-1:0]           rdata_from_dram,
  output logic                            valid_from_dram,
  input  logic                            re_from_dram,
  input  logic [DATA_WIDTH-1:0]           wdata_to_dram,
  input  logic                            we_to_dram,
  output logic                            ready_to_dram,
  output logic                            busy,
  output logic                            transfer_done,
  output logic                            start_collision
);

  localparam int unsigned CW  = WORDS_WIDTH + 1;
  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);

  typedef logic [CW-1:0]         cnt_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  xfer_state_t           state_q, state_d;
  logic [TYPE_WIDTH-1:0] type_q, type_d;
  cnt_t                  n_q, n_d;
  cnt_t                  issued_q, issued_d;
  cnt_t                  received_q, received_d;
  cnt_t                  accepted_q, accepted_d;
  addr_t                 ptr_q [NUM_TYPES];
  addr_t                 ptr_d [NUM_TYPES];
  logic                  pending_q, pending_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  coll_q, coll_d;

  logic                  fifo_push, fifo_pop, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic [FCW-1:0]        fifo_count;

  logic  in_fwd, in_bwd, fwd_req, fwd_gnt, bwd_gnt, capture;
  cnt_t  outstanding;
  addr_t cur_ptr;

  sync_fwft_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_resp_fifo (
    .clk_i  (link_clk),
    .rst_ni (reset),
    .push_i (fifo_push),
    .wdata_i(mem_rdata),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_comb begin
    in_fwd      = (state_q == StFwd);
    in_bwd      = (state_q == StBwd);
    cur_ptr     = ptr_q[type_q];
    outstanding = issued_q - received_q;
    // Credit check: in-flight reads plus buffered words never exceed the FIFO depth.
    fwd_req     = in_fwd && (issued_q < n_q) &&
                  ((outstanding + cnt_t'(fifo_count)) < cnt_t'(FIFO_DEPTH));
    fwd_gnt     = fwd_req && mem_gnt;
    // Responses with nothing outstanding (e.g. stragglers from before a reset) are dropped.
    fifo_push   = in_fwd && mem_rvalid && (received_q != issued_q);
    fifo_pop    = !fifo_empty && re_from_dram;
    bwd_gnt     = in_bwd && pending_q && mem_gnt;
    capture     = ready_to_dram && we_to_dram;
  end

  always_comb begin
    ready_to_dram   = in_bwd && (accepted_q < n_q) && (!pending_q || mem_gnt);
    mem_req         = fwd_req || (in_bwd && pending_q);
    mem_we          = in_bwd && pending_q;
    mem_addr        = mem_req ? cur_ptr : '0;
    mem_wdata       = mem_we ? hold_q : '0;
    valid_from_dram = !fifo_empty;
    rdata_from_dram = fifo_empty ? '0 : fifo_rdata;
    busy            = (state_q != StIdle);
    transfer_done   = (state_q == StDone);
    start_collision = coll_q;
  end

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    n_d        = n_q;
    issued_d   = issued_q;
    received_d = received_q;
    accepted_d = accepted_q;
    pending_d  = pending_q;
    hold_d     = hold_q;
    coll_d     = 1'b0;
    ptr_d      = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (start_forward || start_backward) begin
          state_d    = start_forward ? StFwd : StBwd;
          coll_d     = start_forward && start_backward;
          type_d     = transfer_type;
          n_d        = cnt_t'(words_num);
          issued_d   = '0;
          received_d = '0;
          accepted_d = '0;
          pending_d  = 1'b0;
          if (!transfer_continue) begin
            ptr_d[transfer_type] = base_addr[int'(transfer_type)*ADDR_WIDTH +: ADDR_WIDTH];
          end
        end
      end
      StFwd: begin
        if (fwd_gnt) begin
          ptr_d[type_q] = cur_ptr + addr_t'(1);
          issued_d      = issued_q + cnt_t'(1);
        end
        if (fifo_push) begin
          received_d = received_q + cnt_t'(1);
        end
        if ((issued_q == n_q) && (received_q == n_q) && fifo_empty) begin
          state_d = StDone;
        end
      end
      StBwd: begin
        if (bwd_gnt) begin
          ptr_d[type_q] = cur_ptr + addr_t'(1);
        end
        if (capture) begin
          hold_d     = wdata_to_dram;
          accepted_d = accepted_q + cnt_t'(1);
          pending_d  = 1'b1;
        end else if (bwd_gnt) begin
          pending_d = 1'b0;
        end
        if ((accepted_q == n_q) && !pending_q) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge link_clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      type_q     <= '0;
      n_q        <= '0;
      issued_q   <= '0;
      received_q <= '0;
      accepted_q <= '0;
      pending_q  <= 1'b0;
      hold_q     <= '0;
      coll_q     <= 1'b0;
      for (int k = 0; k < NUM_TYPES; k++) begin
        ptr_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      n_q        <= n_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      accepted_q <= accepted_d;
      pending_q  <= pending_d;
      hold_q     <= hold_d;
      coll_q     <= coll_d;
      ptr_q      <= ptr_d;
    end
  end

endmodule

// File: tb/tb_dram_transfer_engine.sv
// Directed bench for dram_transfer_engine with a latency-configurable memory model.
module tb_dram_transfer_engine;

  localparam int DW = 16;
  localparam int AW = 20;
  localparam int WW = 16;
  localparam int NT = 4;
  localparam int TW = 2;

  logic              link_clk = 1'b0;
  logic              reset;
  logic              start_forward, start_backward;
  logic [TW-1:0]     transfer_type;
  logic              transfer_continue;
  logic [WW-1:0]     words_num;
  logic [NT*AW-1:0]  base_addr;
  logic              mem_req, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [DW-1:0]     mem_rdata = '0;
  logic [DW-1:0]     rdata_from_dram;
  logic              valid_from_dram;
  logic              re_from_dram;
  logic [DW-1:0]     wdata_to_dram;
  logic              we_to_dram;
  logic              ready_to_dram;
  logic              busy, transfer_done, start_collision;

  dram_transfer_engine dut (
    .link_clk         (link_clk),
    .reset            (reset),
    .start_forward    (start_forward),
    .start_backward   (start_backward),
    .transfer_type    (transfer_type),
    .transfer_continue(transfer_continue),
    .words_num        (words_num),
    .base_addr        (base_addr),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_gnt          (mem_gnt),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .rdata_from_dram  (rdata_from_dram),
    .valid_from_dram  (valid_from_dram),
    .re_from_dram     (re_from_dram),
    .wdata_to_dram    (wdata_to_dram),
    .we_to_dram       (we_to_dram),
    .ready_to_dram    (ready_to_dram),
    .busy             (busy),
    .transfer_done    (transfer_done),
    .start_collision  (start_collision)
  );

  always #5 link_clk = ~link_clk;

  int cyc = 0;
  always @(posedge link_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  // Memory-model controls (written by the main process only).
  int gnt_mode = 0;  // 0: always grant, 1: toggle, 2: never
  int lat = 2;
  int start_cyc = 0;

  // Memory-model observations (written by the responder only).
  logic [AW-1:0] rd_addr[$];
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  logic [DW-1:0] rx[$];
  int gnt_cnt = 0, req_cnt = 0, done_cnt = 0, done_cyc = 0, bad_ready = 0, valid_cnt = 0;
  logic [7:0]    pipe_v = 8'h00;
  logic [AW-1:0] pipe_a [8];
  logic          tog = 1'b0;

  function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
    return a[15:0] ^ {a[19:16], 12'h5A3};
  endfunction

  function automatic logic [DW-1:0] bw_word(input int i);
    return 16'hBEE0 + 16'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: drives at negedge+1, observes at negedge+2.
  always begin
    @(negedge link_clk);
    #1;
    pipe_v = pipe_v >> 1;
    for (int i = 0; i < 7; i++) pipe_a[i] = pipe_a[i+1];
    mem_rvalid = pipe_v[0];
    mem_rdata  = pipe_v[0] ? rd_word(pipe_a[0]) : '0;
    tog        = ~tog;
    mem_gnt    = (gnt_mode == 0) || ((gnt_mode == 1) && tog);
    #1;
    if (mem_req) req_cnt++;
    if (mem_req && mem_gnt) begin
      gnt_cnt++;
      if (mem_we) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
      end else begin
        rd_addr.push_back(mem_addr);
        pipe_v[lat] = 1'b1;
        pipe_a[lat] = mem_addr;
      end
    end
    if (mem_req && mem_we && !mem_gnt && ready_to_dram) bad_ready++;
    if (valid_from_dram) valid_cnt++;
    if (valid_from_dram && re_from_dram) rx.push_back(rdata_from_dram);
    if (transfer_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic start_xfer(input logic fwd, input logic bwd, input int t, input logic cont,
                            input int n);
    @(negedge link_clk);
    transfer_type     = TW'(t);
    transfer_continue = cont;
    words_num         = WW'(n);
    start_forward     = fwd;
    start_backward    = bwd;
    start_cyc         = cyc;
    @(negedge link_clk);
    start_forward  = 1'b0;
    start_backward = 1'b0;
  endtask

  task automatic send_words(input int n);
    for (int i = 0; i < n; i++) begin
      int   tries;
      logic acc;
      tries = 0;
      acc   = 1'b0;
      we_to_dram    = 1'b1;
      wdata_to_dram = bw_word(i);
      while (!acc && tries < 50) begin
        #3;
        acc = ready_to_dram;
        tries++;
        @(negedge link_clk);
      end
    end
    we_to_dram = 1'b0;
  endtask

  task automatic wait_done(input int db, input int maxc);
    int k;
    k = 0;
    while (done_cnt == db && k < maxc) begin
      @(negedge link_clk);
      #3;
      k++;
    end
    repeat (2) @(negedge link_clk);
    #3;
  endtask

  typedef struct {
    logic          bwd;
    int            t;
    logic          cont;
    int            n;
    int            gmode;
    int            lt;
    logic [AW-1:0] first;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int rb, wb, xb, db, gb, got;
    logic [AW-1:0] a;
    gnt_mode     = v.gmode;
    lat          = v.lt;
    re_from_dram = 1'b1;
    rb = rd_addr.size();
    wb = wr_addr.size();
    xb = rx.size();
    db = done_cnt;
    gb = gnt_cnt;
    start_xfer(!v.bwd, v.bwd, v.t, v.cont, v.n);
    if (v.bwd) send_words(v.n);
    wait_done(db, 300);
    chk($sformatf("v%0d grants", idx), gnt_cnt - gb, v.n);
    chk($sformatf("v%0d done_pulses", idx), done_cnt - db, 1);
    got = v.bwd ? wr_addr.size() - wb : rx.size() - xb;
    chk($sformatf("v%0d words", idx), got, v.n);
    for (int i = 0; i < v.n && i < got; i++) begin
      a = v.first + AW'(i);
      if (v.bwd) begin
        chk($sformatf("v%0d waddr[%0d]", idx, i), wr_addr[wb+i], a);
        chk($sformatf("v%0d wdata[%0d]", idx, i), wr_data[wb+i], bw_word(i));
      end else begin
        chk($sformatf("v%0d raddr[%0d]", idx, i), rd_addr[rb+i], a);
        chk($sformatf("v%0d rdata[%0d]", idx, i), rx[xb+i], rd_word(a));
      end
    end
  endtask

  vec_t vecs[10];

  initial begin
    int rb, wb, xb, db, gb, rq, vb, k;
    vec_t post[2];

    reset             = 1'b0;
    start_forward     = 1'b0;
    start_backward    = 1'b0;
    transfer_type     = '0;
    transfer_continue = 1'b0;
    words_num         = '0;
    re_from_dram      = 1'b1;
    wdata_to_dram     = '0;
    we_to_dram        = 1'b0;
    base_addr         = {20'hFFFFE, 20'h00040, 20'h00100, 20'h00000};

    // Table: each row's first address follows from the pointer history of earlier rows.
    vecs[0] = '{1'b0, 1, 1'b0, 5, 0, 2, 20'h00100};
    vecs[1] = '{1'b0, 1, 1'b1, 1, 0, 1, 20'h00105};
    vecs[2] = '{1'b0, 0, 1'b0, 4, 0, 2, 20'h00000};
    vecs[3] = '{1'b0, 0, 1'b1, 2, 1, 2, 20'h00004};
    vecs[4] = '{1'b0, 0, 1'b0, 2, 0, 3, 20'h00000};
    vecs[5] = '{1'b1, 2, 1'b0, 3, 1, 2, 20'h00040};
    vecs[6] = '{1'b0, 3, 1'b0, 4, 1, 3, 20'hFFFFE};
    vecs[7] = '{1'b0, 2, 1'b1, 1, 0, 2, 20'h00043};
    vecs[8] = '{1'b1, 3, 1'b1, 2, 0, 2, 20'h00002};
    vecs[9] = '{1'b1, 1, 1'b1, 2, 1, 2, 20'h00106};

    repeat (3) @(negedge link_clk);
    #3;
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst valid", valid_from_dram, 0);
    chk("rst rdata", rdata_from_dram, 0);
    chk("rst ready", ready_to_dram, 0);
    chk("rst busy", busy, 0);
    chk("rst done", transfer_done, 0);
    chk("rst coll", start_collision, 0);
    @(negedge link_clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
    chk("bwd ready while stalled", bad_ready, 0);

    // Backpressure: consumer stalled, credits cap reads at FIFO_DEPTH.
    gnt_mode = 0;
    lat = 2;
    re_from_dram = 1'b0;
    rb = rd_addr.size();
    xb = rx.size();
    db = done_cnt;
    gb = gnt_cnt;
    start_xfer(1'b1, 1'b0, 0, 1'b0, 20);
    repeat (40) @(negedge link_clk);
    #3;
    chk("bp grants capped", gnt_cnt - gb, 8);
    chk("bp mem_req low", mem_req, 0);
    chk("bp valid", valid_from_dram, 1);
    chk("bp nothing popped", rx.size() - xb, 0);
    @(negedge link_clk);
    re_from_dram = 1'b1;
    wait_done(db, 300);
    chk("bp total grants", gnt_cnt - gb, 20);
    chk("bp words", rx.size() - xb, 20);
    chk("bp done", done_cnt - db, 1);
    for (int i = 0; i < 20 && i < rx.size() - xb; i++)
      chk($sformatf("bp rdata[%0d]", i), rx[xb+i], rd_word(AW'(i)));

    // Collision: forward wins; a start during the transfer is ignored.
    rb = rd_addr.size();
    wb = wr_addr.size();
    db = done_cnt;
    gb = gnt_cnt;
    start_xfer(1'b1, 1'b1, 0, 1'b0, 3);
    #3;
    chk("coll pulse", start_collision, 1);
    chk("coll busy", busy, 1);
    @(negedge link_clk);
    start_backward = 1'b1;
    words_num = 7;
    #3;
    chk("coll pulse ends", start_collision, 0);
    @(negedge link_clk);
    start_backward = 1'b0;
    wait_done(db, 300);
    chk("coll grants", gnt_cnt - gb, 3);
    chk("coll no writes", wr_addr.size() - wb, 0);
    chk("coll reads", rd_addr.size() - rb, 3);
    chk("coll done", done_cnt - db, 1);
    chk("coll idle after", busy, 0);

    // Zero-length transfer: done two cycles after start, no memory traffic.
    db = done_cnt;
    rq = req_cnt;
    start_xfer(1'b1, 1'b0, 1, 1'b0, 0);
    wait_done(db, 50);
    chk("zero done", done_cnt - db, 1);
    chk("zero latency", done_cyc - start_cyc, 2);
    chk("zero no req", req_cnt - rq, 0);

    // Reset after three of ten words.
    gnt_mode = 0;
    lat = 2;
    re_from_dram = 1'b1;
    xb = rx.size();
    db = done_cnt;
    start_xfer(1'b1, 1'b0, 0, 1'b0, 10);
    k = 0;
    while (rx.size() - xb < 3 && k < 100) begin
      @(negedge link_clk);
      #3;
      k++;
    end
    reset = 1'b0;
    @(negedge link_clk);
    reset = 1'b1;
    #3;
    chk("mid rst busy", busy, 0);
    chk("mid rst mem_req", mem_req, 0);
    chk("mid rst valid", valid_from_dram, 0);
    chk("mid rst ready", ready_to_dram, 0);
    vb = valid_cnt;
    repeat (6) @(negedge link_clk);
    #3;
    chk("late rvalid dropped", valid_cnt - vb, 0);
    chk("mid rst words", rx.size() - xb, 3);
    chk("mid rst no done", done_cnt - db, 0);
    post[0] = '{1'b0, 1, 1'b0, 3, 0, 2, 20'h00100};
    post[1] = '{1'b0, 2, 1'b1, 1, 0, 2, 20'h00000};
    run_vec(post[0], 10);
    run_vec(post[1], 11);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
